// File: rtl/instr_fetch.sv
// instr_fetch: fetch PC generation, a single-outstanding imem request/response exchange and a {word, pc} prefetch FIFO.
// Build option IFETCH_ALIGN_CHECK_EN: a misaligned redirect target sets fetch_misalign and halts fetch until reset.
module instr_fetch #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PCsrc,
  input  logic [DATA_WIDTH-1:0] ImmOp,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic [DATA_WIDTH-1:0] Instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic                  fetch_misalign
);

  localparam int               PTR_W    = $clog2(FIFO_DEPTH);
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  // state  | meaning
  // S_REQ  | present fetch_pc while a FIFO slot is free
  // S_WAIT | request accepted, its response is pushed
  // S_DROP | request went stale on a redirect, its response is discarded
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_fetch_pc;
  logic [CNT_W-1:0]      r_count;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [DATA_WIDTH-1:0] r_fifo_word [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_fifo_pc   [FIFO_DEPTH];

  logic                  w_empty;
  logic                  w_full;
  logic                  w_halted;
  logic                  w_req_valid;
  logic                  w_req_hs;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_redirect;
  logic [DATA_WIDTH-1:0] w_head_word;
  logic [DATA_WIDTH-1:0] w_head_pc;
  logic [DATA_WIDTH-1:0] w_target_raw;
  logic [DATA_WIDTH-1:0] w_target;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == FULL_CNT);
  assign w_head_word  = r_fifo_word[r_rd_ptr];
  assign w_head_pc    = r_fifo_pc[r_rd_ptr];
  assign w_target_raw = w_head_pc + ImmOp;

  assign w_req_valid  = rst && (r_state == S_REQ) && !w_full && !w_halted;
  assign w_req_hs     = w_req_valid && imem_req_ready;
  assign w_pop        = !w_empty && instr_ready;
  assign w_redirect   = PCsrc && w_pop;
  // a redirect flushes the FIFO, so it wins over a same-cycle response
  assign w_push       = (r_state == S_WAIT) && imem_rsp_valid && !w_redirect;

`ifdef IFETCH_ALIGN_CHECK_EN
  logic r_misalign;

  assign w_target       = w_target_raw;
  assign w_halted       = r_misalign;
  assign fetch_misalign = r_misalign;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_misalign <= 1'b0;
    end else if (w_redirect && (w_target_raw[1:0] != 2'b00)) begin
      r_misalign <= 1'b1;
    end
  end
`else
  assign w_target       = w_target_raw & ~DATA_WIDTH'(3);
  assign w_halted       = 1'b0;
  assign fetch_misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_REQ;
      r_fetch_pc <= RESET_PC;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase

      case (r_state)
        S_REQ: begin
          if (w_req_hs) begin
            r_state    <= S_WAIT;
            r_fetch_pc <= r_fetch_pc + DATA_WIDTH'(4);
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            r_state <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rsp_valid) begin
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_REQ;
      endcase

      if (w_redirect) begin
        r_fetch_pc <= w_target;
        r_count    <= '0;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        if (r_state == S_REQ) begin
          r_state <= w_req_hs ? S_DROP : S_REQ;
        end else begin
          r_state <= imem_rsp_valid ? S_REQ : S_DROP;
        end
      end
    end
  end

  // the response belongs to the address presented before the post-handshake increment
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_word[r_wr_ptr] <= imem_rsp_data;
      r_fifo_pc[r_wr_ptr]   <= r_fetch_pc - DATA_WIDTH'(4);
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_addr      = r_fetch_pc;
  assign instr_valid    = !w_empty;
  assign Instr          = w_empty ? '0 : w_head_word;
  assign instr_pc       = w_empty ? '0 : w_head_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory model with configurable latency, program-order stream scoreboard, directed and random phases.
module tb_instr_fetch;

  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          PCsrc;
  logic [DW-1:0] ImmOp;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [DW-1:0] imem_addr;
  logic          imem_rsp_valid;
  logic [DW-1:0] imem_rsp_data;
  logic [DW-1:0] Instr;
  logic [DW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic          fetch_misalign;

  instr_fetch #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .PCsrc(PCsrc), .ImmOp(ImmOp),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .Instr(Instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .fetch_misalign(fetch_misalign)
  );

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] word;
  } exp_t;

  int            n_checks = 0;
  int            n_errors = 0;
  int            n_pops   = 0;
  int            mem_k    = 1;
  logic          mem_rand = 1'b0;
  logic          word_mode = 1'b0;
  logic [DW-1:0] addr_log [$];
  exp_t          exp_q [$];
  logic [DW-1:0] nxt_pc;

  logic          pend;
  int            lat;
  logic [DW-1:0] paddr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [DW-1:0] mword(input logic [DW-1:0] a);
    return word_mode ? ((a ^ 32'h5EED_0000) + 32'h13) : a;
  endfunction

  function automatic logic [DW-1:0] logged(input int i);
    if (i >= 0 && i < addr_log.size()) return addr_log[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // instruction memory: one request at a time, response k cycles after the accepting edge
  initial begin
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    pend  = 1'b0;
    lat   = 0;
    paddr = '0;
    forever begin
      @(negedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (!rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (lat <= 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mword(paddr);
            pend = 1'b0;
          end else begin
            lat--;
          end
        end
        imem_req_ready = mem_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (imem_req_valid && imem_req_ready) begin
          chk("one_outstanding", {31'd0, pend}, 32'd0);
          pend  = 1'b1;
          paddr = imem_addr;
          lat   = mem_rand ? int'($urandom_range(1, 4)) : mem_k;
          addr_log.push_back(imem_addr);
        end
      end
    end
  end

  // scoreboard: expected program-order stream from the last reset or redirect target
  initial begin
    exp_t e;
    logic [DW-1:0] tgt;
    nxt_pc = 32'h0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        exp_q.delete();
        nxt_pc = 32'h0;
      end else if (instr_valid && instr_ready) begin
        e = exp_q.pop_front();
        chk("pop_pc", instr_pc, e.pc);
        chk("pop_word", Instr, e.word);
        n_pops++;
        if (PCsrc) begin
          tgt = e.pc + ImmOp;
`ifndef IFETCH_ALIGN_CHECK_EN
          tgt[1:0] = 2'b00;
`endif
          exp_q.delete();
          nxt_pc = tgt;
        end
      end
      while (exp_q.size() < 2) begin
        exp_q.push_back('{pc: nxt_pc, word: mword(nxt_pc)});
        nxt_pc = nxt_pc + 32'd4;
      end
    end
  end

  initial begin
    int L;
    int pops_at;
    rst = 1'b0; instr_ready = 1'b0; PCsrc = 1'b0; ImmOp = '0;

    // reset state
    repeat (3) cyc();
    #3;
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", Instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_misalign", {31'd0, fetch_misalign}, 32'd0);

    // release, zero-wait memory, consumer stalled
    cyc(); rst = 1'b1;
    #3;
    chk("rel_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("rel_addr", imem_addr, 32'd0);
    cyc(); #3;
    chk("lat_cycle2_empty", {31'd0, instr_valid}, 32'd0);
    cyc(); #3;
    chk("lat_cycle3_valid", {31'd0, instr_valid}, 32'd1);
    chk("lat_cycle3_instr", Instr, 32'd0);
    chk("lat_cycle3_pc", instr_pc, 32'd0);
    repeat (18) cyc();
    #3;
    chk("hold_req_count", 32'(addr_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("hold_addr", logged(i), 32'(4 * i));
    chk("hold_req_idle", {31'd0, imem_req_valid}, 32'd0);

    // one pop frees exactly one slot
    cyc(); instr_ready = 1'b1;
    cyc(); instr_ready = 1'b0;
    repeat (10) cyc();
    #3;
    chk("pop1_req_count", 32'(addr_log.size()), 32'd5);
    chk("pop1_addr", logged(4), 32'd16);
    chk("pop1_req_idle", {31'd0, imem_req_valid}, 32'd0);

    // redirect from WAIT: pop pc 8 with -8 while the fetch of 20 is in flight
    cyc(); instr_ready = 1'b1; mem_k = 3;
    cyc(); instr_ready = 1'b0;
    cyc(); instr_ready = 1'b1; PCsrc = 1'b1; ImmOp = 32'hFFFF_FFF8;
    cyc(); instr_ready = 1'b0; PCsrc = 1'b0; L = addr_log.size();
    #3;
    chk("redir_flush", {31'd0, instr_valid}, 32'd0);
    chk("redir_inflight_addr", logged(L - 1), 32'd20);
    repeat (12) cyc();
    #3;
    chk("redir_target_addr", logged(L), 32'd0);
    repeat (20) cyc();
    #3;
    chk("redir_refill_idle", {31'd0, imem_req_valid}, 32'd0);
    chk("redir_head_pc", instr_pc, 32'd0);

    // redirect coinciding with a request handshake, k = 3
    cyc(); instr_ready = 1'b1;
    cyc(); PCsrc = 1'b1; ImmOp = 32'h100; L = addr_log.size();
    cyc(); instr_ready = 1'b0; PCsrc = 1'b0;
    #3;
    chk("drop_flush", {31'd0, instr_valid}, 32'd0);
    chk("drop_no_req", {31'd0, imem_req_valid}, 32'd0);
    repeat (12) cyc();
    #3;
    chk("drop_stale_addr", logged(L), 32'd16);
    chk("drop_target_addr", logged(L + 1), 32'h104);
    cyc(); instr_ready = 1'b1;
    repeat (30) cyc();
    instr_ready = 1'b0;

    // misaligned target: pop pc 4 with ImmOp = 2
    cyc(); rst = 1'b0; mem_k = 1;
    repeat (3) cyc();
    rst = 1'b1;
    repeat (14) cyc();
    cyc(); instr_ready = 1'b1;
    cyc(); PCsrc = 1'b1; ImmOp = 32'd2; L = addr_log.size();
    cyc(); instr_ready = 1'b0; PCsrc = 1'b0;
    repeat (10) cyc();
    #3;
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("align_flag", {31'd0, fetch_misalign}, 32'd1);
    chk("align_req_count", 32'(addr_log.size()), 32'(L + 1));
    chk("align_req_idle", {31'd0, imem_req_valid}, 32'd0);
    chk("align_fifo_empty", {31'd0, instr_valid}, 32'd0);
`else
    chk("align_flag", {31'd0, fetch_misalign}, 32'd0);
    chk("align_stale_addr", logged(L), 32'd16);
    chk("align_target_addr", logged(L + 1), 32'd4);
`endif

    // reset asserted while a fetch is outstanding
    cyc(); rst = 1'b0; mem_k = 1;
    repeat (3) cyc();
    rst = 1'b1;
    repeat (3) cyc();
    mem_k = 5;
    cyc();
    cyc(); rst = 1'b0;
    #3;
    chk("wait_pre_valid", {31'd0, instr_valid}, 32'd1);
    chk("rst_wait_req", {31'd0, imem_req_valid}, 32'd0);
    cyc(); #3;
    chk("rst_wait_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_wait_req2", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_wait_instr", Instr, 32'd0);
    cyc(); rst = 1'b1; mem_k = 1; L = addr_log.size();
    cyc(); instr_ready = 1'b1;
    repeat (20) cyc();
    instr_ready = 1'b0;
    #3;
    chk("rst_refetch_addr", logged(L), 32'd0);

    // randomized traffic: random memory ready/latency, consumer stalls and redirects
    cyc(); rst = 1'b0; word_mode = 1'b1; mem_rand = 1'b1;
    repeat (2) cyc();
    rst = 1'b1; pops_at = n_pops;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      instr_ready = ($urandom_range(0, 9) < 6);
      PCsrc       = ($urandom_range(0, 9) == 0);
      ImmOp       = $urandom_range(0, 63) - 32'd32;
`ifdef IFETCH_ALIGN_CHECK_EN
      ImmOp[1:0]  = 2'b00;
`endif
    end
    cyc(); instr_ready = 1'b0; PCsrc = 1'b0;
    #3;
    chk("rand_progress", {31'd0, (n_pops - pops_at) > 100}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
